// File: rtl/code3_pkg.sv
// Shared definitions for the code3_stepper front end: code width,
// debounce state encoding and a counter-width helper.
package code3_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } deb_state_e;

    // Counter width for a modulus of n: $clog2(n), never below 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus a press/release qualification FSM for an
// active-low push-button. Emits a single-cycle press_ok per accepted press.
module key_debounce
    import code3_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic press_ok
);

    localparam int CW = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          w_key_s;
    deb_state_e    r_state;
    deb_state_e    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_press_ok;
    logic          w_press_next;

    assign w_key_s  = r_sync2;
    assign press_ok = r_press_ok;

    // Synchronize the raw key; flops idle high so reset looks like "released".
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // State, qualification counter and registered press strobe.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_press_ok <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_press_ok <= w_press_next;
        end
    end

    // Next-state logic: both edges must stay stable for DEB_CYCLES checks.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_press_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_key_s) begin
                    w_state_next = PRESS_CHK;
                    w_cnt_next   = '0;
                end
            end
            PRESS_CHK: begin
                if (w_key_s) begin
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = HELD;
                    w_press_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (w_key_s) begin
                    w_state_next = REL_CHK;
                    w_cnt_next   = '0;
                end
            end
            REL_CHK: begin
                if (!w_key_s) begin
                    w_state_next = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/code3_stepper.sv
// Drives the A/B/C select lines of a 3-to-8 decoder with a 3-bit code that
// steps on a debounced key press or periodically in auto mode.
module code3_stepper
    import code3_pkg::*;
#(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int AUTO_CYCLES = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    input  logic mode,
    output logic A,
    output logic B,
    output logic C,
    output logic step_pulse
);

    localparam int AW = cnt_w(AUTO_CYCLES);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);

    logic              w_press_ok;
    logic              w_step;
    logic              r_mode;
    logic [AW-1:0]     r_auto_cnt;
    logic              r_auto_tick;
    logic [CODE_W-1:0] r_code;
    logic              r_step_pulse;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_key_debounce (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_n    (key_n),
        .press_ok (w_press_ok)
    );

    // Register mode once; the first auto step then lands AUTO_CYCLES+1
    // edges after mode is first sampled high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode <= 1'b0;
        end else begin
            r_mode <= mode;
        end
    end

    // Auto period counter; a press restarts the period, manual mode parks it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_auto_cnt  <= '0;
            r_auto_tick <= 1'b0;
        end else if (w_press_ok || !r_mode) begin
            r_auto_cnt  <= '0;
            r_auto_tick <= 1'b0;
        end else if (r_auto_cnt == AUTO_LAST) begin
            r_auto_cnt  <= '0;
            r_auto_tick <= 1'b1;
        end else begin
            r_auto_cnt  <= r_auto_cnt + AW'(1);
            r_auto_tick <= 1'b0;
        end
    end

    // Merge step sources. Events in the same cycle count once; an event in
    // the cycle right after a step is absorbed into that step so the strobe
    // can never be high on two consecutive cycles.
    assign w_step = (w_press_ok | r_auto_tick) & ~r_step_pulse;

    // Code register (wraps modulo 8) and its one-cycle change strobe.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_code       <= '0;
            r_step_pulse <= 1'b0;
        end else begin
            if (w_step) begin
                r_code <= r_code + CODE_W'(1);
            end
            r_step_pulse <= w_step;
        end
    end

    assign A          = r_code[2];
    assign B          = r_code[1];
    assign C          = r_code[0];
    assign step_pulse = r_step_pulse;

endmodule

// File: tb/tb_code3_stepper.sv
// Scoreboard bench for code3_stepper: a run-length reference model predicts
// every step (edge number and code), a monitor pops and compares.
`timescale 1ns/1ps
module tb_code3_stepper;

    localparam int DEB  = 4;
    localparam int AUTO = 10;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_n     = 1'b1;
    logic mode      = 1'b0;
    logic A, B, C, step_pulse;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         edge_no;
        logic [2:0] code;
    } exp_t;
    exp_t exp_q[$];

    code3_stepper #(
        .DEB_CYCLES (DEB),
        .AUTO_CYCLES(AUTO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_n     (key_n),
        .mode      (mode),
        .A         (A),
        .B         (B),
        .C         (C),
        .step_pulse(step_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model ----------------
    // key_s lags key_n by two edges. A press is accepted once key_s has been
    // low for DEB+1 consecutive edges while armed; the key re-arms after
    // DEB+1 consecutive high edges. Auto steps fire every AUTO edges counted
    // from the last edge at which mode (seen one edge late) was 0 or a
    // press strobe was visible.
    logic       m_ks1, m_ks2, m_s;
    int         zero_run, one_run;
    bit         armed;
    int         press_edge, anchor, last_step_edge;
    logic       mode_prev;
    logic [2:0] m_code;
    bit         m_press, m_tick;

    task automatic model_reset();
        m_ks1 = 1'b1; m_ks2 = 1'b1;
        zero_run = 0; one_run = 0; armed = 1'b1;
        press_edge = -100; last_step_edge = -100;
        mode_prev = 1'b0; m_code = 3'd0;
        exp_q.delete();
    endtask

    initial model_reset();

    always @(posedge sys_clk) begin
        cyc++;
        if (!sys_rst_n) begin
            model_reset();
            anchor = cyc;
        end else begin
            m_s = m_ks2; m_ks2 = m_ks1; m_ks1 = key_n;
            m_press = 1'b0; m_tick = 1'b0;
            if (m_s == 1'b0) begin zero_run++; one_run = 0; end
            else             begin one_run++;  zero_run = 0; end
            if (armed && zero_run == DEB + 1) begin m_press = 1'b1; armed = 1'b0; end
            else if (!armed && one_run == DEB + 1) armed = 1'b1;
            if (!mode_prev || press_edge == cyc - 1) anchor = cyc;
            else if ((cyc - anchor) % AUTO == 0) m_tick = 1'b1;
            mode_prev = mode;
            if (m_press) press_edge = cyc;
            if ((m_press || m_tick) && last_step_edge != cyc) begin
                m_code = m_code + 3'd1;
                last_step_edge = cyc + 1;
                exp_q.push_back('{cyc + 1, m_code});
            end
        end
    end

    // ---------------- monitor ----------------
    logic [2:0] held = 3'd0;
    exp_t       mon_e;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            held = 3'd0;
        end else if (step_pulse) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step: edge %0d code %b, no step required", cyc, {A, B, C});
            end else begin
                mon_e = exp_q.pop_front();
                held  = mon_e.code;
                if (mon_e.edge_no != cyc || mon_e.code !== {A, B, C}) begin
                    errors++;
                    $display("FAIL step: got edge %0d code %b, required edge %0d code %b",
                             cyc, {A, B, C}, mon_e.edge_no, mon_e.code);
                end else begin
                    $display("step edge %0d code %b ok", cyc, {A, B, C});
                end
            end
        end else begin
            checks++;
            if ({A, B, C} !== held) begin
                errors++;
                $display("FAIL hold: edge %0d code %b, required %b", cyc, {A, B, C}, held);
            end
            if (exp_q.size() > 0 && exp_q[0].edge_no <= cyc) begin
                checks++;
                errors++;
                mon_e = exp_q.pop_front();
                held  = mon_e.code;
                $display("FAIL missed_step: no pulse at edge %0d, required code %b at edge %0d",
                         cyc, mon_e.code, mon_e.edge_no);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic k, input int n);
        key_n = k;
        wait_cyc(n);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({A, B, C, step_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL %s: code %b pulse %b, required 000 / 0", name, {A, B, C}, step_pulse);
        end
    endtask

    int guard;

    initial begin
        wait_cyc(3);
        check_zero("reset_state");
        sys_rst_n = 1'b1;
        wait_cyc(50);

        // clean press, bounced press, too-short pulse
        drive(1'b0, 20); drive(1'b1, 20);
        drive(1'b0, 3);  drive(1'b1, 1); drive(1'b0, 20); drive(1'b1, 20);
        drive(1'b0, 4);  drive(1'b1, 20);

        // eight presses: full wrap of the code
        repeat (8) begin drive(1'b0, 10); drive(1'b1, 10); end

        // auto mode, then back to manual
        mode = 1'b1; wait_cyc(35);
        mode = 1'b0; wait_cyc(30);

        // align press_ok with an auto tick
        mode = 1'b1; wait_cyc(15);
        guard = 0;
        while ((cyc + 7 - anchor) % AUTO != 0 && guard < 2 * AUTO) begin
            wait_cyc(1);
            guard++;
        end
        drive(1'b0, 20); drive(1'b1, 20);
        mode = 1'b0; wait_cyc(10);

        // reset while qualifying a press; key stays low briefly afterwards
        drive(1'b0, 4);
        sys_rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        wait_cyc(2);
        sys_rst_n = 1'b1;
        drive(1'b0, 3); drive(1'b1, 20);
        drive(1'b0, 20); drive(1'b1, 20);

        // randomized presses, bounces and mode changes
        repeat (40) begin
            mode = ($urandom_range(0, 3) == 0);
            drive(1'b0, $urandom_range(1, 12));
            drive(1'b1, $urandom_range(1, 12));
        end
        mode = 1'b0;
        drive(1'b1, 30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d steps still pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
